// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the commit-point exception controller: the bit layout of
// exc_type, the default exception vector, the FSM state encoding, and helpers that
// convert between the exc_type layout and the priority-ordered layout.
package exc_ctrl_pkg;

    // Bit positions inside exc_type (and inside {int_happen, ms_exc}).
    localparam int EXC_INT  = 7;
    localparam int EXC_RINE = 6;
    localparam int EXC_RDAE = 5;
    localparam int EXC_ADES = 4;
    localparam int EXC_SYS  = 3;
    localparam int EXC_BP   = 2;
    localparam int EXC_RI   = 1;
    localparam int EXC_OV   = 0;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hbfc00380;

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_REDIRECT = 1'b1
    } exc_state_e;

    // Reorder an exc_type-layout vector so bit 7 is the highest priority source:
    // int > rine > ri > sys > bp > ov > rdae > ades.
    function automatic logic [7:0] to_prio_order(input logic [7:0] raw);
        return {raw[EXC_INT], raw[EXC_RINE], raw[EXC_RI], raw[EXC_SYS],
                raw[EXC_BP],  raw[EXC_OV],   raw[EXC_RDAE], raw[EXC_ADES]};
    endfunction

    // Inverse of to_prio_order: map a priority-ordered grant back to exc_type layout.
    function automatic logic [7:0] from_prio_order(input logic [7:0] gnt);
        logic [7:0] res;
        res           = 8'h00;
        res[EXC_INT]  = gnt[7];
        res[EXC_RINE] = gnt[6];
        res[EXC_RI]   = gnt[5];
        res[EXC_SYS]  = gnt[4];
        res[EXC_BP]   = gnt[3];
        res[EXC_OV]   = gnt[2];
        res[EXC_RDAE] = gnt[1];
        res[EXC_ADES] = gnt[0];
        return res;
    endfunction

endpackage

// File: rtl/exc_ctrl_prio_enc.sv
// exc_prio_enc: 8-bit fixed-priority one-hot encoder, bit 7 has highest priority.
module exc_prio_enc (
    input  logic [7:0] req,
    output logic [7:0] gnt
);

    // Grant the highest set request bit; no request gives an all-zero grant.
    always_comb begin
        gnt = 8'h00;
        casez (req)
            8'b1???????: gnt = 8'b10000000;
            8'b01??????: gnt = 8'b01000000;
            8'b001?????: gnt = 8'b00100000;
            8'b0001????: gnt = 8'b00010000;
            8'b00001???: gnt = 8'b00001000;
            8'b000001??: gnt = 8'b00000100;
            8'b0000001?: gnt = 8'b00000010;
            8'b00000001: gnt = 8'b00000001;
            default:     gnt = 8'b00000000;
        endcase
    end

endmodule

// File: rtl/exc_ctrl.sv
// Commit-point exception controller: picks the winning exception/interrupt/ERET of
// the committing instruction, pulses it to CP0 one cycle later, and holds a flush
// plus fetch redirect until fetch accepts the new PC.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ms_valid,
    input  logic [31:0] ms_pc,
    input  logic        ms_is_slot,
    input  logic [6:0]  ms_exc,
    input  logic [31:0] ms_bad_vaddr,
    input  logic        ms_eret,
    input  logic        int_happen,
    input  logic [31:0] cp0_epc,
    output logic [7:0]  exc_type,
    output logic [31:0] exc_pc,
    output logic        exc_is_slot,
    output logic [31:0] exc_bad_vaddr,
    output logic        eret,
    output logic        flush,
    output logic        commit_block,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready
);

    exc_state_e  state_r, state_next_s;
    logic        event_s;
    logic [7:0]  prio_req_s;
    logic [7:0]  prio_gnt_s;
    logic [7:0]  win_type_s;
    logic        win_eret_s;
    logic [31:0] win_badv_s;
    logic [31:0] win_target_s;

    logic [7:0]  exc_type_r;
    logic        eret_r;
    logic [31:0] exc_pc_r;
    logic        exc_is_slot_r;
    logic [31:0] exc_bad_vaddr_r;
    logic [31:0] redirect_pc_r;

    assign prio_req_s = to_prio_order({int_happen, ms_exc});

    exc_prio_enc u_prio_enc (
        .req (prio_req_s),
        .gnt (prio_gnt_s)
    );

    // Winner decode: an ERET only wins when no exception or interrupt is present.
    always_comb begin
        event_s      = 1'b0;
        win_type_s   = from_prio_order(prio_gnt_s);
        win_eret_s   = 1'b0;
        win_badv_s   = 32'h0000_0000;
        win_target_s = EXC_VECTOR;
        if (state_r == S_IDLE) begin
            event_s = ms_valid && (int_happen || (|ms_exc) || ms_eret);
        end else begin
            event_s = 1'b0;
        end
        if (win_type_s == 8'h00) begin
            win_eret_s = ms_eret;
        end else begin
            win_eret_s = 1'b0;
        end
        if (win_type_s[EXC_RINE]) begin
            win_badv_s = ms_pc;
        end else if (win_type_s[EXC_RDAE] || win_type_s[EXC_ADES]) begin
            win_badv_s = ms_bad_vaddr;
        end else begin
            win_badv_s = 32'h0000_0000;
        end
        if (win_eret_s) begin
            win_target_s = cp0_epc;
        end else begin
            win_target_s = EXC_VECTOR;
        end
    end

    // Next-state logic: leave REDIRECT only once fetch has taken the new PC.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (event_s) begin
                    state_next_s = S_REDIRECT;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_REDIRECT: begin
                if (redirect_ready) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_REDIRECT;
                end
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Capture the event: single-cycle CP0 pulse, plus context held through REDIRECT.
    always_ff @(posedge clk) begin
        if (rst) begin
            exc_type_r      <= 8'h00;
            eret_r          <= 1'b0;
            exc_pc_r        <= 32'h0000_0000;
            exc_is_slot_r   <= 1'b0;
            exc_bad_vaddr_r <= 32'h0000_0000;
            redirect_pc_r   <= 32'h0000_0000;
        end else if (event_s) begin
            exc_type_r      <= win_type_s;
            eret_r          <= win_eret_s;
            exc_pc_r        <= ms_pc;
            exc_is_slot_r   <= ms_is_slot;
            exc_bad_vaddr_r <= win_badv_s;
            redirect_pc_r   <= win_target_s;
        end else begin
            exc_type_r      <= 8'h00;
            eret_r          <= 1'b0;
        end
    end

    assign exc_type       = exc_type_r;
    assign eret           = eret_r;
    assign exc_pc         = exc_pc_r;
    assign exc_is_slot    = exc_is_slot_r;
    assign exc_bad_vaddr  = exc_bad_vaddr_r;
    assign redirect_pc    = redirect_pc_r;
    assign flush          = (state_r == S_REDIRECT);
    assign redirect_valid = (state_r == S_REDIRECT);
    // Blocking in the detect cycle itself keeps younger instructions from committing.
    assign commit_block   = (state_r == S_REDIRECT) || event_s;

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed vector table, hand-written multi-cycle
// sequences and randomized traffic, all compared every cycle to a behavioural model.
module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ms_valid;
    logic [31:0] ms_pc;
    logic        ms_is_slot;
    logic [6:0]  ms_exc;
    logic [31:0] ms_bad_vaddr;
    logic        ms_eret;
    logic        int_happen;
    logic [31:0] cp0_epc;
    logic [7:0]  exc_type;
    logic [31:0] exc_pc;
    logic        exc_is_slot;
    logic [31:0] exc_bad_vaddr;
    logic        eret;
    logic        flush;
    logic        commit_block;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    int checks = 0;
    int errors = 0;

    exc_ctrl dut (
        .clk(clk), .rst(rst), .ms_valid(ms_valid), .ms_pc(ms_pc),
        .ms_is_slot(ms_is_slot), .ms_exc(ms_exc), .ms_bad_vaddr(ms_bad_vaddr),
        .ms_eret(ms_eret), .int_happen(int_happen), .cp0_epc(cp0_epc),
        .exc_type(exc_type), .exc_pc(exc_pc), .exc_is_slot(exc_is_slot),
        .exc_bad_vaddr(exc_bad_vaddr), .eret(eret), .flush(flush),
        .commit_block(commit_block), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .redirect_ready(redirect_ready)
    );

    always #5 clk = ~clk;

    // Behavioural model state: what the outputs must show this cycle.
    bit          m_busy;
    logic [7:0]  m_type;
    logic        m_eret;
    logic [31:0] m_pc;
    logic        m_slot;
    logic [31:0] m_badv;
    logic [31:0] m_rpc;

    // Winner by scanning exc_type bit positions in priority order.
    function automatic logic [7:0] model_winner(input logic intr, input logic [6:0] exc);
        int         order [8] = '{7, 6, 1, 3, 2, 0, 5, 4};
        logic [7:0] raw;
        logic [7:0] r;
        raw = {intr, exc};
        r   = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (r == 8'h00 && raw[order[i]]) r[order[i]] = 1'b1;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_event();
        return !m_busy && ms_valid && (int_happen || (|ms_exc) || ms_eret);
    endfunction

    // Compare every output with the model, then advance the model across the next edge.
    task automatic cycle_check_update();
        logic [7:0] w;
        bit         ev;
        ev = model_event();
        chk("exc_type", {24'h0, exc_type}, {24'h0, m_type});
        chk("eret", {31'h0, eret}, {31'h0, m_eret});
        chk("flush", {31'h0, flush}, {31'h0, m_busy});
        chk("redirect_valid", {31'h0, redirect_valid}, {31'h0, m_busy});
        chk("commit_block", {31'h0, commit_block}, {31'h0, (m_busy || ev)});
        chk("redirect_pc", redirect_pc, m_rpc);
        if (m_type != 8'h00) begin
            chk("exc_pc", exc_pc, m_pc);
            chk("exc_is_slot", {31'h0, exc_is_slot}, {31'h0, m_slot});
            chk("exc_bad_vaddr", exc_bad_vaddr, m_badv);
        end
        if (rst) begin
            m_busy = 0; m_type = 8'h00; m_eret = 1'b0; m_pc = 32'h0;
            m_slot = 1'b0; m_badv = 32'h0; m_rpc = 32'h0;
        end else if (ev) begin
            w      = model_winner(int_happen, ms_exc);
            m_busy = 1;
            m_type = w;
            m_eret = (w == 8'h00);
            m_pc   = ms_pc;
            m_slot = ms_is_slot;
            m_badv = w[6] ? ms_pc : ((w[5] || w[4]) ? ms_bad_vaddr : 32'h0);
            m_rpc  = (w == 8'h00) ? cp0_epc : 32'hbfc00380;
        end else begin
            m_type = 8'h00;
            m_eret = 1'b0;
            if (m_busy && redirect_ready) m_busy = 0;
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic slot,
                         input logic [6:0] exc, input logic [31:0] badv, input logic er,
                         input logic intr, input logic [31:0] epc, input logic rdy,
                         input logic r);
        @(negedge clk);
        rst = r; ms_valid = v; ms_pc = pc; ms_is_slot = slot; ms_exc = exc;
        ms_bad_vaddr = badv; ms_eret = er; int_happen = intr; cp0_epc = epc;
        redirect_ready = rdy;
        #1;
        cycle_check_update();
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 32'h0, 1'b0, 7'h00, 32'h0, 1'b0, 1'b0, 32'h0, rdy, 1'b0);
    endtask

    typedef struct {
        logic [31:0] pc;
        logic        slot;
        logic [6:0]  exc;
        logic [31:0] badv;
        logic        er;
        logic        intr;
        logic [31:0] epc;
        logic [7:0]  e_type;
        logic        e_eret;
        logic [31:0] e_badv;
        logic [31:0] e_rpc;
    } vec_t;

    vec_t vecs [6];
    int   pulses;

    initial begin
        vecs[0] = '{32'h80001000, 1'b0, 7'b0000010, 32'h0, 1'b0, 1'b0, 32'h0,
                    8'h02, 1'b0, 32'h0, 32'hbfc00380};
        vecs[1] = '{32'h80000003, 1'b0, 7'b1000001, 32'h0, 1'b0, 1'b0, 32'h0,
                    8'h40, 1'b0, 32'h80000003, 32'hbfc00380};
        vecs[2] = '{32'h80000010, 1'b0, 7'b0000000, 32'h0, 1'b1, 1'b0, 32'h80002004,
                    8'h00, 1'b1, 32'h0, 32'h80002004};
        vecs[3] = '{32'h80000020, 1'b1, 7'b0010000, 32'h55aa0000, 1'b0, 1'b1, 32'h0,
                    8'h80, 1'b0, 32'h0, 32'hbfc00380};
        vecs[4] = '{32'h80000030, 1'b0, 7'b0100000, 32'h12345678, 1'b0, 1'b0, 32'h0,
                    8'h20, 1'b0, 32'h12345678, 32'hbfc00380};
        vecs[5] = '{32'h80000040, 1'b0, 7'b0000001, 32'h0, 1'b1, 1'b0, 32'h80009999,
                    8'h01, 1'b0, 32'h0, 32'hbfc00380};

        m_busy = 0; m_type = 8'h00; m_eret = 1'b0; m_pc = 32'h0;
        m_slot = 1'b0; m_badv = 32'h0; m_rpc = 32'h0;

        // Reset and reset-state outputs.
        drive(1'b0, 32'h0, 1'b0, 7'h00, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 7'h00, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        idle(1'b0);
        chk("reset_exc_pc", exc_pc, 32'h0);
        chk("reset_badv", exc_bad_vaddr, 32'h0);

        // Directed table: event in T, pulse in T+1 accepted at once, IDLE in T+2.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, vecs[i].pc, vecs[i].slot, vecs[i].exc, vecs[i].badv,
                  vecs[i].er, vecs[i].intr, vecs[i].epc, 1'b0, 1'b0);
            chk("tbl_commit_block_T", {31'h0, commit_block}, 32'h1);
            idle(1'b1);
            chk("tbl_type", {24'h0, exc_type}, {24'h0, vecs[i].e_type});
            chk("tbl_eret", {31'h0, eret}, {31'h0, vecs[i].e_eret});
            chk("tbl_rpc", redirect_pc, vecs[i].e_rpc);
            chk("tbl_flush", {31'h0, flush}, 32'h1);
            if (vecs[i].e_type != 8'h00) begin
                chk("tbl_pc", exc_pc, vecs[i].pc);
                chk("tbl_slot", {31'h0, exc_is_slot}, {31'h0, vecs[i].slot});
                chk("tbl_badv", exc_bad_vaddr, vecs[i].e_badv);
            end
            idle(1'b0);
            chk("tbl_back_idle", {31'h0, flush}, 32'h0);
        end

        // Interrupt without a valid instruction waits.
        drive(1'b0, 32'h80000100, 1'b0, 7'h00, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
        idle(1'b1);
        chk("int_no_valid", {24'h0, exc_type}, 32'h0);

        // Stalled redirect with a sys instruction arriving meanwhile.
        pulses = 0;
        drive(1'b1, 32'h80000200, 1'b0, 7'b0000010, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h80000204, 1'b0, 7'b0001000, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
            if (exc_type != 8'h00) pulses++;
            chk("stall_flush", {31'h0, flush}, 32'h1);
        end
        idle(1'b1);
        if (exc_type != 8'h00) pulses++;
        chk("stall_single_pulse", pulses, 1);
        idle(1'b0);
        chk("stall_released", {31'h0, flush}, 32'h0);

        // Reset during REDIRECT abandons it.
        drive(1'b1, 32'h80000300, 1'b0, 7'b0000100, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        idle(1'b0);
        drive(1'b0, 32'h0, 1'b0, 7'h00, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        idle(1'b0);
        chk("rst_redirect_flush", {31'h0, flush}, 32'h0);
        chk("rst_redirect_type", {24'h0, exc_type}, 32'h0);
        chk("rst_redirect_rpc", redirect_pc, 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 1) == 1,
                  $urandom, $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'h00,
                  $urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                  $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);
        end
        idle(1'b1);
        idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
